// File: rtl/btn_pkg.sv
// Shared definitions for the button conditioner and the downstream ALU stage:
// debounce FSM state encoding and button index assignments.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    CHK_HIGH  = 2'd1,
    IDLE_HIGH = 2'd2,
    CHK_LOW   = 2'd3
  } db_state_t;

  localparam int unsigned BTN_A  = 2;
  localparam int unsigned BTN_B  = 1;
  localparam int unsigned BTN_OP = 0;

endpackage

// File: rtl/debounce_cell.sv
// One button: 2-flop synchroniser, stability counter and debounce FSM.
// accept is combinational and high on the edge that commits a press.
module debounce_cell
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic accept,
  output logic level
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          meta;
  logic          sync;
  db_state_t     state;
  db_state_t     state_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta  <= 1'b0;
      sync  <= 1'b0;
      state <= IDLE_LOW;
      cnt   <= '0;
    end else begin
      meta  <= raw;
      sync  <= meta;
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Counter is cleared on every entry to an IDLE state, so it never exceeds LAST.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    case (state)
      IDLE_LOW: begin
        if (sync) begin
          state_next = CHK_HIGH;
          cnt_next   = CW'(1);
        end else begin
          cnt_next = '0;
        end
      end
      CHK_HIGH: begin
        if (!sync) begin
          state_next = IDLE_LOW;
          cnt_next   = '0;
        end else if (cnt == LAST) begin
          state_next = IDLE_HIGH;
          cnt_next   = '0;
          accept     = 1'b1;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      IDLE_HIGH: begin
        if (!sync) begin
          state_next = CHK_LOW;
          cnt_next   = CW'(1);
        end else begin
          cnt_next = '0;
        end
      end
      CHK_LOW: begin
        if (sync) begin
          state_next = IDLE_HIGH;
          cnt_next   = '0;
        end else if (cnt == LAST) begin
          state_next = IDLE_LOW;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      default: begin
        state_next = IDLE_LOW;
        cnt_next   = '0;
      end
    endcase
  end

  assign level = (state == IDLE_HIGH) || (state == CHK_LOW);

endmodule

// File: rtl/btn_debounce_pulse.sv
// Board input conditioner: debounced one-hot press pulses with a switch
// snapshot aligned to each pulse, feeding the ALU stage directly.
module btn_debounce_pulse
  import btn_pkg::*;
#(
  parameter int unsigned N_BUTTONS       = 3,
  parameter int unsigned N_SW            = 6,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N_BUTTONS-1:0] i_buttons_raw,
  input  logic [N_SW-1:0]      i_SWs_raw,
  output logic [N_BUTTONS-1:0] o_buttons,
  output logic [N_SW-1:0]      o_SWs,
  output logic                 o_collision
);

  logic [N_BUTTONS-1:0] accept;
  logic [N_BUTTONS-1:0] unused_level;
  logic [N_SW-1:0]      sw_meta;
  logic [N_SW-1:0]      sw_sync;
  logic [N_BUTTONS-1:0] winner;
  logic                 multi;
  logic                 seen;

  for (genvar g = 0; g < int'(N_BUTTONS); g++) begin : g_cell
    debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cell (
      .clock (clock),
      .reset (reset),
      .raw   (i_buttons_raw[g]),
      .accept(accept[g]),
      .level (unused_level[g])
    );
  end

  // Ascending scan: the highest accepted index overwrites lower ones (A > B > OP).
  always_comb begin
    winner = '0;
    multi  = 1'b0;
    seen   = 1'b0;
    for (int unsigned i = 0; i < N_BUTTONS; i++) begin
      if (accept[i]) begin
        winner    = '0;
        winner[i] = 1'b1;
        if (seen) multi = 1'b1;
        seen = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sw_meta     <= '0;
      sw_sync     <= '0;
      o_buttons   <= '0;
      o_SWs       <= '0;
      o_collision <= 1'b0;
    end else begin
      sw_meta     <= i_SWs_raw;
      sw_sync     <= sw_meta;
      o_buttons   <= winner;
      o_collision <= multi;
      if (|winner) o_SWs <= sw_sync;
    end
  end

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Directed bench for btn_debounce_pulse with DEBOUNCE_CYCLES=4, clock period 2.
`timescale 1ns/1ps
module tb_btn_debounce_pulse;

  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] i_buttons_raw;
  logic [5:0] i_SWs_raw;
  logic [2:0] o_buttons;
  logic [5:0] o_SWs;
  logic       o_collision;

  int checks = 0;
  int errors = 0;
  logic [5:0] exp_sw;

  always #1 clock = ~clock;

  btn_debounce_pulse #(
    .N_BUTTONS(3),
    .N_SW(6),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .i_buttons_raw(i_buttons_raw),
    .i_SWs_raw    (i_SWs_raw),
    .o_buttons    (o_buttons),
    .o_SWs        (o_SWs),
    .o_collision  (o_collision)
  );

  // One rising edge passes; outputs are then sampled at the falling edge.
  task automatic tick();
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      i_buttons_raw = (i % 2 == 0) ? 3'b111 : 3'b000;
      i_SWs_raw     = (i % 2 == 0) ? 6'b101010 : 6'b010101;
      tick();
      checks++;
      if (o_buttons !== 3'b000 || o_SWs !== 6'b000000 || o_collision !== 1'b0) begin
        errors++;
        $display("FAIL reset cyc %0d got btn=%b sw=%b col=%b exp 000/000000/0",
                 i, o_buttons, o_SWs, o_collision);
      end
    end
    i_buttons_raw = 3'b000;
    i_SWs_raw     = 6'b000000;
    tick();
    reset  = 1'b0;
    exp_sw = 6'b000000;
    for (int i = 0; i < 4; i++) tick();
  endtask

  // Holds pattern for n cycles; expects pulse exp_b (and collision exp_c) only on cycle pulse_at.
  task automatic run_window(input string name, input logic [2:0] pattern, input int n,
                            input int pulse_at, input logic [2:0] exp_b, input logic exp_c);
    logic [2:0] eb;
    logic       ec;
    i_buttons_raw = pattern;
    for (int i = 1; i <= n; i++) begin
      tick();
      eb = (i == pulse_at) ? exp_b : 3'b000;
      ec = (i == pulse_at) ? exp_c : 1'b0;
      if (i == pulse_at) exp_sw = i_SWs_raw;
      checks++;
      if (o_buttons !== eb) begin
        errors++;
        $display("FAIL %s btn cyc %0d got %b exp %b", name, i, o_buttons, eb);
      end
      checks++;
      if (o_collision !== ec) begin
        errors++;
        $display("FAIL %s col cyc %0d got %b exp %b", name, i, o_collision, ec);
      end
      checks++;
      if (o_SWs !== exp_sw) begin
        errors++;
        $display("FAIL %s sw cyc %0d got %b exp %b", name, i, o_SWs, exp_sw);
      end
    end
  endtask

  task automatic test_clean_press();
    i_SWs_raw = 6'b000011;
    run_window("idle", 3'b000, 4, 0, 3'b000, 1'b0);
    run_window("clean_press", 3'b100, 12, 6, 3'b100, 1'b0);
    checks++;
    if (exp_sw !== 6'b000011) begin
      errors++;
      $display("FAIL clean_snapshot got %b exp 000011", exp_sw);
    end
    run_window("clean_release", 3'b000, 10, 0, 3'b000, 1'b0);
  endtask

  task automatic test_bounce();
    logic [2:0] seq [4] = '{3'b010, 3'b000, 3'b010, 3'b000};
    logic [2:0] rel [3] = '{3'b000, 3'b010, 3'b000};
    for (int i = 0; i < 4; i++) run_window("bounce_in", seq[i], 1, 0, 3'b000, 1'b0);
    run_window("bounce_press", 3'b010, 12, 6, 3'b010, 1'b0);
    for (int i = 0; i < 3; i++) run_window("bounce_rel", rel[i], 1, 0, 3'b000, 1'b0);
    run_window("bounce_release", 3'b000, 10, 0, 3'b000, 1'b0);
  endtask

  task automatic test_collision();
    run_window("collision", 3'b011, 12, 6, 3'b010, 1'b1);
    run_window("collision_rel", 3'b000, 10, 0, 3'b000, 1'b0);
    run_window("collision_op", 3'b001, 12, 6, 3'b001, 1'b0);
    run_window("collision_op_rel", 3'b000, 10, 0, 3'b000, 1'b0);
  endtask

  task automatic test_reset_mid();
    run_window("mid_count", 3'b001, 4, 0, 3'b000, 1'b0);
    reset = 1'b1;
    tick();
    reset  = 1'b0;
    exp_sw = 6'b000000;
    checks++;
    if (o_buttons !== 3'b000 || o_SWs !== 6'b000000 || o_collision !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got btn=%b sw=%b col=%b exp 000/000000/0",
               o_buttons, o_SWs, o_collision);
    end
    run_window("after_reset", 3'b001, 12, 6, 3'b001, 1'b0);
    run_window("after_reset_rel", 3'b000, 10, 0, 3'b000, 1'b0);
  endtask

  task automatic test_snapshot();
    i_SWs_raw = 6'b000111;
    run_window("snap_first", 3'b001, 12, 6, 3'b001, 1'b0);
    run_window("snap_first_rel", 3'b000, 10, 0, 3'b000, 1'b0);
    i_SWs_raw = 6'b100010;
    run_window("snap_hold", 3'b000, 10, 0, 3'b000, 1'b0);
    checks++;
    if (o_SWs !== 6'b000111) begin
      errors++;
      $display("FAIL snap_hold_value got %b exp 000111", o_SWs);
    end
    run_window("snap_second", 3'b001, 12, 6, 3'b001, 1'b0);
    checks++;
    if (o_SWs !== 6'b100010) begin
      errors++;
      $display("FAIL snap_second_value got %b exp 100010", o_SWs);
    end
  endtask

  initial begin
    reset         = 1'b1;
    i_buttons_raw = 3'b000;
    i_SWs_raw     = 6'b000000;
    exp_sw        = 6'b000000;
    test_reset();
    test_clean_press();
    test_bounce();
    test_collision();
    test_reset_mid();
    test_snapshot();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
